// File: rtl/fetch_unit.sv
// simpleRisc instruction-fetch stage: PC register, credit-limited memory
// requests, and a PC-tagged fetch queue draining to decode.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              isBranchTaken,
    input  logic [ADDR_W-1:0] branchPC,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] PC
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
    localparam logic [CW:0] LIMIT = (CW + 1)'(FQ_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [INST_W-1:0] inst_mem_q [FQ_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [FQ_DEPTH];

    logic [ADDR_W-1:0] target;
    logic [CW:0]       used;
    logic              issue;
    logic              drop;
    logic              push;
    logic              pop;

    // Masking keeps every branchPC bit in the expression; the low two are forced to 0.
    assign target = branchPC & ~ADDR_W'(3);
    assign used   = {1'b0, count_q} + {1'b0, outst_q};

    assign imem_req_valid = !reset && !isBranchTaken && (used < LIMIT);
    assign imem_req_addr  = fetch_pc_q;
    assign PC             = fetch_pc_q;

    assign inst_valid = (count_q != '0) && !isBranchTaken;
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

    assign issue = imem_req_valid && imem_req_ready;
    assign drop  = imem_rsp_valid && (discard_q != '0);
    assign push  = imem_rsp_valid && !drop && !isBranchTaken;
    assign pop   = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (isBranchTaken) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + STEP;
            if (push)  rsp_pc_d   = rsp_pc_q + STEP;
        end
    end

    always_comb begin
        outst_d = outst_q;
        unique case ({issue, imem_rsp_valid})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    // A redirect re-derives discard from the in-flight count, so it never stacks.
    always_comb begin
        discard_d = discard_q;
        if (isBranchTaken) begin
            discard_d = outst_q - CW'(imem_rsp_valid);
        end else if (drop) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (isBranchTaken) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency
// instruction memory model and a delivery monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        isBranchTaken = 1'b0;
    logic [31:0] branchPC = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] PC;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .isBranchTaken(isBranchTaken),
        .branchPC(branchPC),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .PC(PC)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    logic [31:0] pend_a[$];
    int          pend_d[$];
    logic [31:0] req_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_dat[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          lat_cfg = 1;
    logic        mem_clr = 1'b0;
    logic        s_req;
    logic        s_rsp;
    logic [31:0] s_addr;

    // Memory model and monitor: sample at negedge, update just after posedge.
    always begin
        @(negedge clk);
        s_req  = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        s_rsp  = imem_rsp_valid;
        if (s_req) req_log.push_back(s_addr);
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_dat.push_back(inst);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (mem_clr) begin
            pend_a.delete();
            pend_d.delete();
        end else begin
            if (s_rsp && pend_a.size() > 0) begin
                void'(pend_a.pop_front());
                void'(pend_d.pop_front());
            end
            if (s_req) begin
                pend_a.push_back(s_addr);
                pend_d.push_back(cyc + lat_cfg);
            end
        end
        cyc++;
        if (!mem_clr && pend_a.size() > 0 && pend_d[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(pend_a[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        reset = 1'b1;
        mem_clr = 1'b1;
        isBranchTaken = 1'b0;
        branchPC = '0;
        inst_ready = 1'b0;
        step(2);
        lat_cfg = lat;
        req_log.delete();
        got_pc.delete();
        got_dat.delete();
        got_cyc.delete();
        reset = 1'b0;
        mem_clr = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] a);
        isBranchTaken = 1'b1;
        branchPC = a;
        step(1);
        isBranchTaken = 1'b0;
    endtask

    task automatic chk_got(input string nm, input int i, input logic [31:0] pc);
        checks++;
        if (got_pc.size() <= i) begin
            $display("FAIL %s[%0d] missing, have %0d deliveries", nm, i, got_pc.size());
            errors++;
        end else if (got_pc[i] !== pc || got_dat[i] !== memw(pc)) begin
            $display("FAIL %s[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                     nm, i, got_pc[i], got_dat[i], pc, memw(pc));
            errors++;
        end
    endtask

    task automatic chk_req(input string nm, input int i, input logic [31:0] a);
        checks++;
        if (req_log.size() <= i) begin
            $display("FAIL %s[%0d] missing, have %0d requests", nm, i, req_log.size());
            errors++;
        end else if (req_log[i] !== a) begin
            $display("FAIL %s[%0d] got addr=%h want %h", nm, i, req_log[i], a);
            errors++;
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            $display("FAIL reset_valids got %b want 00", {imem_req_valid, inst_valid});
            errors++;
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            $display("FAIL reset_head got inst=%h pc=%h want 0/0", inst, inst_pc);
            errors++;
        end
        checks++;
        if (PC !== 32'h0) begin
            $display("FAIL reset_pc got %h want 0", PC);
            errors++;
        end
    endtask

    task automatic test_stream;
        do_reset(1);
        inst_ready = 1'b1;
        step(14);
        for (int i = 0; i < 4; i++) chk_req("stream_req", i, 32'(4 * i));
        for (int i = 0; i < 8; i++) chk_got("stream_got", i, 32'(4 * i));
        checks++;
        if (got_cyc.size() < 8 || got_cyc[7] - got_cyc[0] != 7) begin
            $display("FAIL stream_gapless got %0d deliveries, span %0d want span 7",
                     got_cyc.size(), got_cyc.size() >= 8 ? got_cyc[7] - got_cyc[0] : -1);
            errors++;
        end
    endtask

    task automatic test_full_queue;
        do_reset(3);
        step(20);
        checks++;
        if (req_log.size() != 4) begin
            $display("FAIL full_req_count got %0d want 4", req_log.size());
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b01) begin
            $display("FAIL full_stall got req/inst valid %b want 01",
                     {imem_req_valid, inst_valid});
            errors++;
        end
        checks++;
        if (PC !== 32'h10) begin
            $display("FAIL full_pc got %h want 00000010", PC);
            errors++;
        end
        step(1);
        inst_ready = 1'b1;
        step(15);
        for (int i = 0; i < 4; i++) chk_got("full_drain", i, 32'(4 * i));
        chk_req("full_resume", 4, 32'h10);
    endtask

    task automatic test_redirect;
        do_reset(8);
        inst_ready = 1'b1;
        redirect(32'h20);
        step(3);
        isBranchTaken = 1'b1;
        branchPC = 32'h103;
        step(1);
        isBranchTaken = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin
            $display("FAIL redir_next got addr=%h valid=%b want 00000100/1",
                     imem_req_addr, imem_req_valid);
            errors++;
        end
        step(40);
        chk_req("redir_req", 0, 32'h20);
        chk_req("redir_req", 2, 32'h28);
        chk_req("redir_req", 3, 32'h100);
        chk_got("redir_got", 0, 32'h100);
        chk_got("redir_got", 1, 32'h104);
    endtask

    task automatic test_redirect_rsp;
        do_reset(1);
        step(2);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1) begin
            $display("FAIL rr_pre got inst_valid=%b want 1", inst_valid);
            errors++;
        end
        step(1);
        isBranchTaken = 1'b1;
        branchPC = 32'h200;
        @(negedge clk);
        checks++;
        if ({inst_valid, imem_req_valid} !== 2'b00) begin
            $display("FAIL rr_during got inst/req valid %b want 00",
                     {inst_valid, imem_req_valid});
            errors++;
        end
        step(1);
        isBranchTaken = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || PC !== 32'h200) begin
            $display("FAIL rr_after got inst_valid=%b pc=%h want 0/00000200",
                     inst_valid, PC);
            errors++;
        end
        step(10);
        chk_got("rr_got", 0, 32'h200);
        chk_got("rr_got", 1, 32'h204);
    endtask

    task automatic test_back_to_back;
        bit bad;
        do_reset(6);
        inst_ready = 1'b1;
        step(2);
        redirect(32'h40);
        redirect(32'h80);
        step(40);
        chk_req("b2b_req", 1, 32'h4);
        chk_req("b2b_req", 2, 32'h80);
        chk_got("b2b_got", 0, 32'h80);
        chk_got("b2b_got", 2, 32'h88);
        bad = 1'b0;
        foreach (got_pc[i]) if (got_pc[i] < 32'h80) bad = 1'b1;
        checks++;
        if (bad || got_pc.size() == 0) begin
            $display("FAIL b2b_stale got %0d deliveries, stale=%b want none stale",
                     got_pc.size(), bad);
            errors++;
        end
    endtask

    task automatic test_wrap_and_async_reset;
        do_reset(1);
        inst_ready = 1'b1;
        redirect(32'hFFFF_FFF8);
        step(8);
        chk_req("wrap_req", 0, 32'hFFFF_FFF8);
        chk_req("wrap_req", 1, 32'hFFFF_FFFC);
        chk_req("wrap_req", 2, 32'h0);
        chk_got("wrap_got", 0, 32'hFFFF_FFF8);
        chk_got("wrap_got", 2, 32'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        mem_clr = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            $display("FAIL async_valids got %b want 00", {imem_req_valid, inst_valid});
            errors++;
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || PC !== 32'h0) begin
            $display("FAIL async_regs got inst=%h inst_pc=%h pc=%h want 0/0/0",
                     inst, inst_pc, PC);
            errors++;
        end
        step(2);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_queue();
        test_redirect();
        test_redirect_rsp();
        test_back_to_back();
        test_wrap_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Clocked, parametrised instruction-fetch stage for the simpleRisc core.
- Holds the fetch PC register and issues sequential word fetches to an instruction memory with variable, in-order response latency.
- Buffers returned instructions, each tagged with its PC, in a small fetch queue that drains to decode over a valid/ready handshake.
- A taken branch redirects the PC, flushes the queue and discards all in-flight responses.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2. Also the outstanding-request limit.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- isBranchTaken  in  1  redirect strobe, one cycle per taken branch.
- branchPC  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_W  fetch address; equals fetch_pc.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  INST_W  response instruction word.
- inst_valid  out  1  queue head valid toward decode.
- inst_ready  in  1  decode accepts the queue head.
- inst  out  INST_W  instruction at the queue head.
- inst_pc  out  ADDR_W  PC of the instruction at the queue head.
- PC  out  ADDR_W  current fetch_pc; for debug and trace.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue count=0, outstanding=0, discard=0.
  - Outputs during reset: imem_req_valid=0, inst_valid=0, inst/inst_pc=0, PC=RESET_PC.
  - Reset asserted mid-transfer abandons everything. Any late responses after reset are the memory's responsibility; the bench resets the memory model too.
- Credit rule: imem_req_valid = !reset && !isBranchTaken && (count + outstanding) < FQ_DEPTH.
  - "outstanding" counts all in-flight requests, including those marked for discard.
  - Counter width is clog2(FQ_DEPTH+1).
- Issue: when imem_req_valid && imem_req_ready:
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W (0xFFFFFFFC → 0 at ADDR_W=32).
  - outstanding increments.
- Response, in a cycle when imem_rsp_valid=1:
  - outstanding decrements.
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise: push {rsp_pc, imem_rsp_data} into the queue and rsp_pc <= rsp_pc + 4.
  - The credit rule guarantees no push ever occurs when the queue is full.
  - A response arriving with outstanding=0 is illegal; the bench asserts this never happens.
- Issue and response in the same cycle: outstanding is unchanged.
- Drain:
  - inst_valid = (count != 0) && !isBranchTaken.
  - Pop when inst_valid && inst_ready. Queue head registers drive inst and inst_pc.
  - Push and pop in the same cycle: count is unchanged, data order is preserved.
  - When empty, inst_valid=0 and inst/inst_pc hold their last value (don't-care).
- Redirect (isBranchTaken=1), all in one cycle:
  - fetch_pc <= {branchPC[ADDR_W-1:2],2'b00}; rsp_pc <= same value.
  - count <= 0: the queue is flushed and no pop happens this cycle.
  - No request is issued this cycle.
  - discard <= outstanding − (imem_rsp_valid ? 1 : 0). A response arriving this cycle is dropped.
  - outstanding is updated normally.
  - A redirect while discard>0 recomputes discard by the same formula, so discards do not accumulate.
- PC output always equals fetch_pc, the next address to be requested.
- No combinational path from imem_rsp_* to inst_*. isBranchTaken has a combinational path to imem_req_valid and inst_valid.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 → requests at 0,4,8,…; inst_pc stream 0,4,8,… with the matching memory words; no gaps after pipeline fill.
- inst_ready=0, FQ_DEPTH=4, 3-cycle memory → exactly 4 requests issued (0..0xC), then imem_req_valid=0 with count=4. Raise inst_ready → 0x0,0x4,0x8,0xC drain in order, and fetch resumes at 0x10.
- Redirect to 0x103 with 3 requests outstanding (addresses 0x20..0x28) → next request addr=0x100. The 3 stale responses are dropped, and the first inst_pc out is 0x100 with data from 0x100.
- Redirect in the same cycle as a response and with the queue non-empty → queue empties, inst_valid=0 that cycle, stale response dropped, discard = outstanding−1.
- Back-to-back redirects to 0x40 then 0x80 with 2 outstanding → only 0x80-stream instructions are delivered; discard never exceeds outstanding.
- ADDR_W=32, branchPC=0xFFFFFFF8 → fetch sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Assert async reset mid-stream → outputs take reset values immediately, before the next clock edge.
